// File: rtl/pc_branch_unit_32.sv
// Program counter with a four-state branch resolver (IDLE -> WAIT -> RESOLVE -> ACK).
// Optional taken-branch statistics counter enabled by defining BRANCH_STATS_EN.
module pc_branch_unit_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic [31:0] BUS,
  input  logic        PCin,
  input  logic        IncPC,
  input  logic        br_req,
  output logic        busy,
  output logic        br_ack,
  output logic        taken,
  output logic [31:0] PC
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] br_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESOLVE,
    S_ACK
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] disp;
  logic [31:0] pc_next;
  logic        disp_load;
  logic        unused_ir;

  assign unused_ir = ^IR[31:19];

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (br_req) state_next = S_WAIT;
      S_WAIT:    state_next = S_RESOLVE;
      S_RESOLVE: state_next = S_ACK;
      S_ACK:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_WAIT) || (state == S_RESOLVE);
    disp_load = (state == S_IDLE) && br_req;
    pc_next   = PC;
    case (state)
      S_IDLE, S_ACK: begin
        if (PCin)       pc_next = BUS;
        else if (IncPC) pc_next = PC + 32'd1;
      end
      S_RESOLVE: if (CON) pc_next = PC + disp;
      default: pc_next = PC;
    endcase
  end

  // br_ack is registered off the ACK state, so it appears the cycle after ACK is left.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      PC     <= RESET_PC;
      disp   <= '0;
      taken  <= 1'b0;
      br_ack <= 1'b0;
    end else begin
      PC     <= pc_next;
      br_ack <= (state == S_ACK);
      if (disp_load) disp <= {{13{IR[18]}}, IR[18:0]};
      if (state == S_RESOLVE) taken <= CON;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      br_count <= '0;
    end else if ((state == S_RESOLVE) && CON && (br_count != 16'hFFFF)) begin
      br_count <= br_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pc_branch_unit_32.md
PC_BRANCH_UNIT_32 -- requirements
Module: pc_branch_unit_32

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the value loaded into PC on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Clr  input  1  asynchronous active-high reset.
REQ-005 IR  input  32  instruction register; IR[18:0] = branch displacement C2.
REQ-006 CON  input  1  branch flag from the conditional flip-flop stage (1 = take branch).
REQ-007 BUS  input  32  datapath bus; PC load source.
REQ-008 PCin  input  1  load PC from BUS.
REQ-009 IncPC  input  1  increment PC by 1.
REQ-010 br_req  input  1  request branch resolution.
REQ-011 busy  output  1  high while a branch is in flight (states WAIT, RESOLVE).
REQ-012 br_ack  output  1  one-cycle pulse: branch resolved.
REQ-013 taken  output  1  result of the most recent resolved branch.
REQ-014 PC  output  32  program counter.
REQ-015 br_count  output  16  taken-branch count; present only with BRANCH_STATS_EN.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESOLVE, ACK; encoding is free.
REQ-017 IDLE: br_req=1 SHALL latch disp = sign-extend(IR[18:0]) to 32 bits and move to WAIT.
REQ-018 WAIT SHALL last exactly one cycle (CON settle), then move to RESOLVE unconditionally.
REQ-019 RESOLVE SHALL sample CON; if 1, PC <= PC + disp (mod 2^32); if 0, PC unchanged; taken <= CON; move to ACK.
REQ-020 ACK SHALL assert br_ack for exactly one cycle, then return to IDLE.
REQ-021 Latency: br_req accepted at edge E -> br_ack high in the cycle after edge E+3.
REQ-022 In IDLE and ACK, PCin=1 SHALL load PC <= BUS; else IncPC=1 SHALL load PC <= PC+1 (PCin has priority).
REQ-023 In WAIT and RESOLVE, PCin, IncPC and br_req SHALL be ignored.
REQ-024 br_req in ACK SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 br_req and IncPC in the same IDLE cycle: both take effect; the branch target is relative to the incremented PC.
REQ-026 PC+1 and PC+disp SHALL wrap modulo 2^32 (FFFF_FFFF+1 = 0000_0000).
REQ-027 IR changes after acceptance SHALL NOT affect the in-flight displacement.
REQ-028 taken SHALL hold its value until the next RESOLVE.

Reset
REQ-029 Clr=1 SHALL immediately force: state IDLE, PC=RESET_PC, busy=0, br_ack=0, taken=0, disp=0, br_count=0.
REQ-030 Clr asserted mid-branch SHALL abort it with no br_ack and no PC update.
REQ-031 While Clr=1, all inputs SHALL be ignored.

Configuration
REQ-032 Macro BRANCH_STATS_EN defined: br_count SHALL increment by 1 on every RESOLVE with CON=1, saturating at 16'hFFFF.
REQ-033 Macro BRANCH_STATS_EN undefined: the br_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Clr pulse, RESET_PC=32'h100 -> PC=32'h100, busy=0, br_ack=0, taken=0.
REQ-035 PC=32'h10, IR[18:0]=19'h00020, br_req, CON=1 in RESOLVE -> PC=32'h30, taken=1, br_ack one cycle, 4 edges after acceptance.
REQ-036 PC=32'h10, IR[18:0]=19'h7FFF0 (-16), CON=1 -> PC=32'h0; with CON=0 -> PC=32'h10, taken=0.
REQ-037 PC=32'hFFFF_FFFF, IncPC -> PC=32'h0; PCin=1 with IncPC=1, BUS=32'hABCD -> PC=32'hABCD.
REQ-038 br_req accepted, Clr asserted in WAIT -> PC=RESET_PC, no br_ack; IncPC/PCin during WAIT/RESOLVE -> PC unchanged.
REQ-039 BRANCH_STATS_EN: 3 taken + 2 not-taken branches -> br_count=3; preset near 16'hFFFF then taken branch -> stays 16'hFFFF.
